// File: rtl/otter_trap_seq_if.sv
// Bundle of every non-clock signal between the execute stage and the trap
// sequencer.
//   master modport : core side. It drives the request, PC and CSR snapshot
//                    (i_*) and receives stall, CSR write and redirect (o_*).
//   slave modport  : otter_trap_seq side, with the opposite directions.
// There is no valid/ready pair on this bus. A request is taken in the cycle
// i_valid is high while the sequencer is idle, and o_stall rises in that same
// cycle. While o_stall is high the sequencer ignores every i_* input except
// i_mtvec and i_mepc. It reads those live when it forms the redirect target.
interface otter_trap_seq_if #(
  parameter int XLEN   = 32,
  parameter int EXCP_W = 4
);
  logic              i_valid;
  logic [EXCP_W-1:0] i_excp_sel;
  logic [XLEN-1:0]   i_trap_mtval;
  logic [XLEN-1:0]   i_pc_addr;
  logic              i_mret;
  logic              i_irq;
  logic [XLEN-1:0]   i_mstatus;
  logic [XLEN-1:0]   i_mtvec;
  logic [XLEN-1:0]   i_mepc;
  logic              o_stall;
  logic              o_csr_we;
  logic [11:0]       o_csr_addr;
  logic [XLEN-1:0]   o_csr_wdata;
  logic              o_pc_redirect;
  logic [XLEN-1:0]   o_pc_target;

  modport master (
    output i_valid, i_excp_sel, i_trap_mtval, i_pc_addr, i_mret, i_irq,
           i_mstatus, i_mtvec, i_mepc,
    input  o_stall, o_csr_we, o_csr_addr, o_csr_wdata, o_pc_redirect, o_pc_target
  );

  modport slave (
    input  i_valid, i_excp_sel, i_trap_mtval, i_pc_addr, i_mret, i_irq,
           i_mstatus, i_mtvec, i_mepc,
    output o_stall, o_csr_we, o_csr_addr, o_csr_wdata, o_pc_redirect, o_pc_target
  );
endinterface

// File: rtl/otter_trap_seq.sv
// Machine-mode trap entry and MRET exit sequencer for the OTTER core.
// On a request it stalls the pipeline. It then writes the CSRs one per cycle
// through the single CSR write port and finishes with a one-cycle PC redirect.
// Ports:
//   i_clk       rising-edge clock
//   i_rst_n     asynchronous active-low reset
//   bus         otter_trap_seq_if.slave carrying the request, CSR snapshot,
//               stall, CSR write and redirect signals
//   o_dbg_state current FSM state, exposed for observation
module otter_trap_seq #(
  parameter int              XLEN      = 32,
  parameter int              EXCP_W    = 4,
  parameter logic [XLEN-1:0] IRQ_CAUSE = 32'h8000000B
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  otter_trap_seq_if.slave       bus,
  output logic [2:0]            o_dbg_state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_W_EPC   = 3'd1;
  localparam logic [2:0] S_W_CAUSE = 3'd2;
  localparam logic [2:0] S_W_TVAL  = 3'd3;
  localparam logic [2:0] S_W_STAT  = 3'd4;
  localparam logic [2:0] S_REDIR   = 3'd5;
  localparam logic [2:0] S_M_STAT  = 3'd6;
  localparam logic [2:0] S_REDIR_M = 3'd7;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  // Clears the low two bits of a target address. Any mtvec mode bits are dropped.
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

  // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= M.
  function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] m);
    logic [XLEN-1:0] s;
    s        = m;
    s[7]     = m[3];
    s[3]     = 1'b0;
    s[12:11] = 2'b11;
    return s;
  endfunction

  // MRET: MIE <= MPIE, MPIE <= 1, MPP stays M (only M-mode is implemented).
  function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] m);
    logic [XLEN-1:0] s;
    s        = m;
    s[3]     = m[7];
    s[7]     = 1'b1;
    s[12:11] = 2'b11;
    return s;
  endfunction

  logic [2:0]      state_q,     state_d;
  logic [XLEN-1:0] cause_q,     cause_d;
  logic [XLEN-1:0] mtval_q,     mtval_d;
  logic [XLEN-1:0] mstat_q,     mstat_d;
  logic            csr_we_q,    csr_we_d;
  logic [11:0]     csr_addr_q,  csr_addr_d;
  logic [XLEN-1:0] csr_wdata_q, csr_wdata_d;
  logic            redir_q,     redir_d;
  logic [XLEN-1:0] target_q,    target_d;
  logic            accept;

  // The CSR port and redirect outputs are flops loaded with the values that
  // belong to the next state. Every write therefore appears in the cycle its
  // state is active, and every output reads 0 once the FSM is back in IDLE.
  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    mtval_d     = mtval_q;
    mstat_d     = mstat_q;
    csr_we_d    = 1'b0;
    csr_addr_d  = 12'h000;
    csr_wdata_d = '0;
    redir_d     = 1'b0;
    target_d    = '0;
    accept      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.i_valid) begin
          if (bus.i_excp_sel != '0) begin
            accept      = 1'b1;
            state_d     = S_W_EPC;
            cause_d     = {{(XLEN-EXCP_W){1'b0}}, bus.i_excp_sel};
            mtval_d     = bus.i_trap_mtval;
            mstat_d     = bus.i_mstatus;
            csr_we_d    = 1'b1;
            csr_addr_d  = CSR_MEPC;
            csr_wdata_d = bus.i_pc_addr;
          end else if (bus.i_irq && bus.i_mstatus[3]) begin
            // The interrupted instruction has not executed, so mepc gets its PC.
            accept      = 1'b1;
            state_d     = S_W_EPC;
            cause_d     = IRQ_CAUSE;
            mtval_d     = '0;
            mstat_d     = bus.i_mstatus;
            csr_we_d    = 1'b1;
            csr_addr_d  = CSR_MEPC;
            csr_wdata_d = bus.i_pc_addr;
          end else if (bus.i_mret) begin
            accept      = 1'b1;
            state_d     = S_M_STAT;
            mstat_d     = bus.i_mstatus;
            csr_we_d    = 1'b1;
            csr_addr_d  = CSR_MSTATUS;
            csr_wdata_d = mret_mstatus(bus.i_mstatus);
          end
        end
      end
      S_W_EPC: begin
        state_d     = S_W_CAUSE;
        csr_we_d    = 1'b1;
        csr_addr_d  = CSR_MCAUSE;
        csr_wdata_d = cause_q;
      end
      S_W_CAUSE: begin
        state_d     = S_W_TVAL;
        csr_we_d    = 1'b1;
        csr_addr_d  = CSR_MTVAL;
        csr_wdata_d = mtval_q;
      end
      S_W_TVAL: begin
        state_d     = S_W_STAT;
        csr_we_d    = 1'b1;
        csr_addr_d  = CSR_MSTATUS;
        csr_wdata_d = trap_mstatus(mstat_q);
      end
      S_W_STAT: begin
        state_d  = S_REDIR;
        redir_d  = 1'b1;
        target_d = bus.i_mtvec & ALIGN_MASK;
      end
      S_M_STAT: begin
        state_d  = S_REDIR_M;
        redir_d  = 1'b1;
        target_d = bus.i_mepc & ALIGN_MASK;
      end
      S_REDIR, S_REDIR_M: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      cause_q     <= '0;
      mtval_q     <= '0;
      mstat_q     <= '0;
      csr_we_q    <= 1'b0;
      csr_addr_q  <= 12'h000;
      csr_wdata_q <= '0;
      redir_q     <= 1'b0;
      target_q    <= '0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      mtval_q     <= mtval_d;
      mstat_q     <= mstat_d;
      csr_we_q    <= csr_we_d;
      csr_addr_q  <= csr_addr_d;
      csr_wdata_q <= csr_wdata_d;
      redir_q     <= redir_d;
      target_q    <= target_d;
    end
  end

  // Stall rises combinationally in the accept cycle and stays high through
  // the redirect cycle.
  assign bus.o_stall       = accept || (state_q != S_IDLE);
  assign bus.o_csr_we      = csr_we_q;
  assign bus.o_csr_addr    = csr_addr_q;
  assign bus.o_csr_wdata   = csr_wdata_q;
  assign bus.o_pc_redirect = redir_q;
  assign bus.o_pc_target   = target_q;
  assign o_dbg_state       = state_q;

endmodule

// File: tb/tb_otter_trap_seq.sv
// Directed testbench for otter_trap_seq. Each task drives one scenario and
// checks the DUT outputs inline against hand-computed values.
module tb_otter_trap_seq;

  logic       clk;
  logic       rst_n;
  logic [2:0] dbg_state;
  int         errors;
  int         checks;

  otter_trap_seq_if #(.XLEN(32), .EXCP_W(4)) bus ();

  otter_trap_seq #(.XLEN(32), .EXCP_W(4), .IRQ_CAUSE(32'h8000000B)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .bus        (bus),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- drivers ----------------
  task automatic idle_inputs();
    bus.i_valid      = 1'b0;
    bus.i_excp_sel   = 4'h0;
    bus.i_trap_mtval = 32'h0;
    bus.i_pc_addr    = 32'h0;
    bus.i_mret       = 1'b0;
    bus.i_irq        = 1'b0;
    bus.i_mstatus    = 32'h0;
  endtask

  task automatic drive_req(input logic [3:0] excp, input logic [31:0] mtval,
                           input logic [31:0] pc, input logic irq, input logic mret,
                           input logic [31:0] mstatus);
    bus.i_valid      = 1'b1;
    bus.i_excp_sel   = excp;
    bus.i_trap_mtval = mtval;
    bus.i_pc_addr    = pc;
    bus.i_irq        = irq;
    bus.i_mret       = mret;
    bus.i_mstatus    = mstatus;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    bus.i_mtvec = 32'h0;
    bus.i_mepc  = 32'h0;
    repeat (2) @(negedge clk);
    checks++; if (bus.o_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b exp 0", bus.o_stall); end
    checks++; if (bus.o_csr_we !== 1'b0) begin errors++; $display("FAIL reset_we got %0b exp 0", bus.o_csr_we); end
    checks++; if (bus.o_csr_addr !== 12'h0) begin errors++; $display("FAIL reset_addr got %h exp 000", bus.o_csr_addr); end
    checks++; if (bus.o_csr_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h exp 0", bus.o_csr_wdata); end
    checks++; if (bus.o_pc_redirect !== 1'b0) begin errors++; $display("FAIL reset_redirect got %0b exp 0", bus.o_pc_redirect); end
    checks++; if (bus.o_pc_target !== 32'h0) begin errors++; $display("FAIL reset_target got %h exp 0", bus.o_pc_target); end
    rst_n = 1'b1;
  endtask

  // Full trap entry. With scramble set, the request inputs are changed to
  // other values while the sequence is busy, and the writes must not change.
  task automatic test_trap_entry(input string name, input logic [3:0] excp,
                                 input logic [31:0] mtval, input logic [31:0] pc,
                                 input logic irq, input logic mret,
                                 input logic [31:0] mstatus, input logic [31:0] mtvec,
                                 input logic [31:0] e_cause, input logic [31:0] e_mtval,
                                 input logic [31:0] e_stat, input logic [31:0] e_target,
                                 input bit scramble);
    logic        ew, er, es;
    logic [11:0] ea;
    logic [31:0] ed, et;
    @(posedge clk); #1;
    bus.i_mtvec = mtvec;
    drive_req(excp, mtval, pc, irq, mret, mstatus);
    @(negedge clk);
    checks++; if (bus.o_stall !== 1'b1) begin errors++; $display("FAIL %s accept_stall got %0b exp 1", name, bus.o_stall); end
    checks++; if (bus.o_csr_we !== 1'b0) begin errors++; $display("FAIL %s accept_we got %0b exp 0", name, bus.o_csr_we); end
    @(posedge clk); #1;
    idle_inputs();
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      ew = 1'b0; ea = 12'h0; ed = 32'h0; er = 1'b0; et = 32'h0; es = 1'b1;
      case (k)
        1: begin ew = 1'b1; ea = 12'h341; ed = pc;      end
        2: begin ew = 1'b1; ea = 12'h342; ed = e_cause; end
        3: begin ew = 1'b1; ea = 12'h343; ed = e_mtval; end
        4: begin ew = 1'b1; ea = 12'h300; ed = e_stat;  end
        5: begin er = 1'b1; et = e_target;              end
        default: es = 1'b0;
      endcase
      checks++; if (bus.o_csr_we !== ew) begin errors++; $display("FAIL %s T+%0d csr_we got %0b exp %0b", name, k, bus.o_csr_we, ew); end
      checks++; if (bus.o_csr_addr !== ea) begin errors++; $display("FAIL %s T+%0d csr_addr got %h exp %h", name, k, bus.o_csr_addr, ea); end
      checks++; if (bus.o_csr_wdata !== ed) begin errors++; $display("FAIL %s T+%0d csr_wdata got %h exp %h", name, k, bus.o_csr_wdata, ed); end
      checks++; if (bus.o_pc_redirect !== er) begin errors++; $display("FAIL %s T+%0d redirect got %0b exp %0b", name, k, bus.o_pc_redirect, er); end
      checks++; if (bus.o_pc_target !== et) begin errors++; $display("FAIL %s T+%0d target got %h exp %h", name, k, bus.o_pc_target, et); end
      checks++; if (bus.o_stall !== es) begin errors++; $display("FAIL %s T+%0d stall got %0b exp %0b", name, k, bus.o_stall, es); end
      if (scramble && k <= 4)
        drive_req(4'($urandom_range(1, 15)), $urandom, $urandom, 1'b1, 1'b1, $urandom);
      else
        idle_inputs();
    end
  endtask

  // A request that must not be taken: no stall and no write for several cycles.
  task automatic test_no_accept(input string name, input logic valid,
                                input logic [3:0] excp, input logic irq,
                                input logic [31:0] mstatus);
    @(posedge clk); #1;
    drive_req(excp, 32'h55, 32'h80, irq, 1'b0, mstatus);
    bus.i_valid = valid;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (bus.o_stall !== 1'b0) begin errors++; $display("FAIL %s cyc%0d stall got %0b exp 0", name, k, bus.o_stall); end
      checks++; if (bus.o_csr_we !== 1'b0) begin errors++; $display("FAIL %s cyc%0d csr_we got %0b exp 0", name, k, bus.o_csr_we); end
      checks++; if (bus.o_pc_redirect !== 1'b0) begin errors++; $display("FAIL %s cyc%0d redirect got %0b exp 0", name, k, bus.o_pc_redirect); end
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_mret();
    @(posedge clk); #1;
    bus.i_mepc = 32'h204;
    drive_req(4'h0, 32'h0, 32'h400, 1'b0, 1'b1, 32'h1880);
    @(negedge clk);
    checks++; if (bus.o_stall !== 1'b1) begin errors++; $display("FAIL mret T stall got %0b exp 1", bus.o_stall); end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    checks++; if (bus.o_csr_we !== 1'b1) begin errors++; $display("FAIL mret T+1 csr_we got %0b exp 1", bus.o_csr_we); end
    checks++; if (bus.o_csr_addr !== 12'h300) begin errors++; $display("FAIL mret T+1 csr_addr got %h exp 300", bus.o_csr_addr); end
    checks++; if (bus.o_csr_wdata !== 32'h1888) begin errors++; $display("FAIL mret T+1 csr_wdata got %h exp 00001888", bus.o_csr_wdata); end
    checks++; if (bus.o_stall !== 1'b1) begin errors++; $display("FAIL mret T+1 stall got %0b exp 1", bus.o_stall); end
    @(negedge clk);
    checks++; if (bus.o_csr_we !== 1'b0) begin errors++; $display("FAIL mret T+2 csr_we got %0b exp 0", bus.o_csr_we); end
    checks++; if (bus.o_pc_redirect !== 1'b1) begin errors++; $display("FAIL mret T+2 redirect got %0b exp 1", bus.o_pc_redirect); end
    checks++; if (bus.o_pc_target !== 32'h204) begin errors++; $display("FAIL mret T+2 target got %h exp 00000204", bus.o_pc_target); end
    checks++; if (bus.o_stall !== 1'b1) begin errors++; $display("FAIL mret T+2 stall got %0b exp 1", bus.o_stall); end
    @(negedge clk);
    checks++; if (bus.o_stall !== 1'b0) begin errors++; $display("FAIL mret T+3 stall got %0b exp 0", bus.o_stall); end
    checks++; if (bus.o_pc_redirect !== 1'b0) begin errors++; $display("FAIL mret T+3 redirect got %0b exp 0", bus.o_pc_redirect); end
  endtask

  task automatic test_reset_mid_sequence();
    @(posedge clk); #1;
    bus.i_mtvec = 32'h101;
    drive_req(4'h4, 32'h1002, 32'h200, 1'b0, 1'b0, 32'h8);
    @(posedge clk); #1;
    idle_inputs();
    repeat (3) @(negedge clk);
    checks++; if (bus.o_csr_addr !== 12'h343) begin errors++; $display("FAIL rst_mid W_TVAL addr got %h exp 343", bus.o_csr_addr); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.o_csr_we !== 1'b0) begin errors++; $display("FAIL rst_mid async csr_we got %0b exp 0", bus.o_csr_we); end
    checks++; if (bus.o_csr_addr !== 12'h0) begin errors++; $display("FAIL rst_mid async csr_addr got %h exp 000", bus.o_csr_addr); end
    checks++; if (bus.o_csr_wdata !== 32'h0) begin errors++; $display("FAIL rst_mid async csr_wdata got %h exp 0", bus.o_csr_wdata); end
    checks++; if (bus.o_stall !== 1'b0) begin errors++; $display("FAIL rst_mid async stall got %0b exp 0", bus.o_stall); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (bus.o_csr_we !== 1'b0) begin errors++; $display("FAIL rst_mid post%0d csr_we got %0b exp 0", k, bus.o_csr_we); end
      checks++; if (bus.o_pc_redirect !== 1'b0) begin errors++; $display("FAIL rst_mid post%0d redirect got %0b exp 0", k, bus.o_pc_redirect); end
      checks++; if (bus.o_stall !== 1'b0) begin errors++; $display("FAIL rst_mid post%0d stall got %0b exp 0", k, bus.o_stall); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_trap_entry("load_misalign", 4'h4, 32'h1002, 32'h200, 1'b0, 1'b0, 32'h8, 32'h101,
                    32'h4, 32'h1002, 32'h1880, 32'h100, 1'b0);
    test_trap_entry("irq", 4'h0, 32'h1234, 32'h40, 1'b1, 1'b0, 32'h8, 32'h80,
                    32'h8000000B, 32'h0, 32'h1880, 32'h80, 1'b0);
    test_no_accept("irq_masked", 1'b1, 4'h0, 1'b1, 32'h0);
    test_no_accept("valid_low", 1'b0, 4'h4, 1'b1, 32'h8);
    test_trap_entry("excp_over_irq_mret", 4'h2, 32'h77, 32'h300, 1'b1, 1'b1, 32'h8, 32'h203,
                    32'h2, 32'h77, 32'h1880, 32'h200, 1'b0);
    test_mret();
    test_reset_mid_sequence();
    test_trap_entry("busy_ignore", 4'hF, 32'hDEADBEEF, 32'h1000, 1'b0, 1'b0, 32'h0, 32'hFFFFFFFF,
                    32'hF, 32'hDEADBEEF, 32'h1800, 32'hFFFFFFFC, 1'b1);
    test_trap_entry("back_to_back", 4'h1, 32'h0, 32'h404, 1'b0, 1'b0, 32'h88, 32'h2000,
                    32'h1, 32'h0, 32'h1880, 32'h2000, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
